// File: rtl/mdu_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit: op codes, FSM states, counter width.
// MADD/MADDU are only recognised as operations when MDU_MADD_EN is defined.
package mdu_pkg;

  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MTHI  = 4'd5;
  localparam logic [3:0] MDU_MTLO  = 4'd6;
  localparam logic [3:0] MDU_MADD  = 4'd7;
  localparam logic [3:0] MDU_MADDU = 4'd8;

  localparam int CNT_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdu_state_t;

  function automatic logic is_mul_op(input logic [3:0] op);
`ifdef MDU_MADD_EN
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_MADD) || (op == MDU_MADDU);
`else
    return (op == MDU_MULT) || (op == MDU_MULTU);
`endif
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/e_mdu_arith.sv
// Combinational datapath of the MDU: multiply, divide and (with MDU_MADD_EN) multiply-accumulate.
// Produces the HI/LO values to commit, plus a divide-by-zero flag that suppresses the commit.
module e_mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [31:0] next_hi,
  output logic [31:0] next_lo,
  output logic        div0
);

  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, b_safe, b_mag_safe;
  logic [31:0] uq, ur, sq_mag, sr_mag;

  // Low 64 bits of a product of sign-extended operands equal the signed product.
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'b0, a} * {32'b0, b};

  // Signed divide works on magnitudes; 0x80000000 has magnitude 0x80000000 unsigned, so /-1 wraps cleanly.
  assign a_mag      = a[31] ? (~a + 32'd1) : a;
  assign b_mag      = b[31] ? (~b + 32'd1) : b;
  assign b_safe     = (b == 32'd0) ? 32'd1 : b;
  assign b_mag_safe = (b == 32'd0) ? 32'd1 : b_mag;
  assign uq         = a / b_safe;
  assign ur         = a % b_safe;
  assign sq_mag     = a_mag / b_mag_safe;
  assign sr_mag     = a_mag % b_mag_safe;

  always_comb begin
    next_hi = hi;
    next_lo = lo;
    div0    = 1'b0;
    case (op)
      MDU_MULT:  {next_hi, next_lo} = prod_s;
      MDU_MULTU: {next_hi, next_lo} = prod_u;
      MDU_DIV: begin
        div0    = (b == 32'd0);
        next_lo = (a[31] ^ b[31]) ? (~sq_mag + 32'd1) : sq_mag;
        next_hi = a[31] ? (~sr_mag + 32'd1) : sr_mag;
      end
      MDU_DIVU: begin
        div0    = (b == 32'd0);
        next_lo = uq;
        next_hi = ur;
      end
`ifdef MDU_MADD_EN
      MDU_MADD:  {next_hi, next_lo} = {hi, lo} + prod_s;
      MDU_MADDU: {next_hi, next_lo} = {hi, lo} + prod_u;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: owns HI/LO, models multi-cycle latency with busy.
// Build with MDU_MADD_EN defined to add MADD/MADDU accumulate operations.
//
//  state | meaning
//  IDLE  | accepts start; mthi/mtlo write immediately, mult/div class ops latch operands
//  BUSY  | counting down latency; HI/LO commit when the counter reaches 1
module e_mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MULT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(DIV_CYCLES);

  mdu_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       op_q;
  logic [31:0]      a_q, b_q;
  logic [31:0]      next_hi, next_lo;
  logic             div0;

  // Accumulate base is HI/LO as held at commit; nothing can write them while busy.
  e_mdu_arith u_arith (
    .op      (op_q),
    .a       (a_q),
    .b       (b_q),
    .hi      (HI),
    .lo      (LO),
    .next_hi (next_hi),
    .next_lo (next_lo),
    .div0    (div0)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      cnt   <= '0;
      op_q  <= MDU_NONE;
      a_q   <= '0;
      b_q   <= '0;
      HI    <= '0;
      LO    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (is_mul_op(op) || is_div_op(op)) begin
              op_q  <= op;
              a_q   <= A;
              b_q   <= B;
              cnt   <= is_div_op(op) ? CNT_DIV : CNT_MULT;
              state <= BUSY;
              busy  <= 1'b1;
            end else if (op == MDU_MTHI) begin
              HI <= A;
            end else if (op == MDU_MTLO) begin
              LO <= A;
            end
          end
        end
        BUSY: begin
          if (cnt == CNT_ONE) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
            if (!div0) begin
              HI <= next_hi;
              LO <= next_lo;
            end
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: directed vector table, hand-written corner sequences, random ops vs a reference model.
// Define MDU_MADD_EN for both bench and RTL to exercise MADD/MADDU.
module tb_e_mdu;
  import mdu_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset, start, busy;
  logic [3:0]  op;
  logic [31:0] A, B, HI, LO;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi, m_lo;

  always #5 clk = ~clk;

  e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .HI    (HI),
    .LO    (LO)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference: architectural meaning of each op using 64-bit integer arithmetic.
  function automatic void ref_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] hi, input logic [31:0] lo,
                                 output logic [31:0] nhi, output logic [31:0] nlo, output int cyc);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    nhi = hi; nlo = lo; cyc = 0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (o)
      MDU_MULT:  begin p = 64'(sa * sb); {nhi, nlo} = p; cyc = MC; end
      MDU_MULTU: begin p = 64'(ua * ub); {nhi, nlo} = p; cyc = MC; end
      MDU_DIV: begin
        cyc = DC;
        if (b != 32'd0) begin nlo = 32'(sa / sb); nhi = 32'(sa % sb); end
      end
      MDU_DIVU: begin
        cyc = DC;
        if (b != 32'd0) begin nlo = 32'(ua / ub); nhi = 32'(ua % ub); end
      end
      MDU_MTHI: nhi = a;
      MDU_MTLO: nlo = a;
`ifdef MDU_MADD_EN
      MDU_MADD:  begin p = {hi, lo} + 64'(sa * sb); {nhi, nlo} = p; cyc = MC; end
      MDU_MADDU: begin p = {hi, lo} + 64'(ua * ub); {nhi, nlo} = p; cyc = MC; end
`endif
      default: ;
    endcase
  endfunction

  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input int ecyc, input string nm);
    int cyc;
    logic held;
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b;
    @(negedge clk);
    start = 1'b0; op = MDU_NONE; A = $urandom; B = $urandom;
    cyc = 0; held = 1'b1;
    while (busy === 1'b1 && cyc < 200) begin
      if (HI !== m_hi || LO !== m_lo) held = 1'b0;
      cyc++;
      @(negedge clk);
    end
    chk({nm, " cycles"}, 64'(cyc), 64'(ecyc));
    chk({nm, " hold"}, 64'(held), 64'(1));
    chk({nm, " HI"}, 64'(HI), 64'(ehi));
    chk({nm, " LO"}, 64'(LO), 64'(elo));
    m_hi = ehi; m_lo = elo;
  endtask

  initial begin
    int cyc;
    logic [3:0]  ro;
    logic [31:0] ra, rb, ehi, elo;
    int ecyc;
    logic [3:0] ops[$];

    tbl[0]  = '{MDU_MULT,  32'hFFFFFFFD, 32'd4,        32'hFFFFFFFF, 32'hFFFFFFF4, MC};
    tbl[1]  = '{MDU_DIVU,  32'd7,        32'd2,        32'd1,        32'd3,        DC};
    tbl[2]  = '{MDU_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DC};
    tbl[3]  = '{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, DC};
    tbl[4]  = '{MDU_MTHI,  32'h11,       32'd0,        32'h11,       32'h80000000, 0};
    tbl[5]  = '{MDU_MTLO,  32'h22,       32'd0,        32'h11,       32'h22,       0};
    tbl[6]  = '{MDU_DIV,   32'd5,        32'd0,        32'h11,       32'h22,       DC};
    tbl[7]  = '{MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MC};
    tbl[8]  = '{MDU_MTHI,  32'hABCD,     32'd0,        32'hABCD,     32'h00000001, 0};
    tbl[9]  = '{MDU_NONE,  32'h1234,     32'h5678,     32'hABCD,     32'h00000001, 0};
    tbl[10] = '{4'd15,     32'h1234,     32'h5678,     32'hABCD,     32'h00000001, 0};
    tbl[11] = '{MDU_DIVU,  32'hFFFFFFFF, 32'd16,       32'h0000000F, 32'h0FFFFFFF, DC};

    reset = 1'b1; start = 1'b0; op = MDU_NONE; A = '0; B = '0;
    repeat (2) @(negedge clk);
    chk("reset busy", 64'(busy), 64'(0));
    chk("reset HI", 64'(HI), 64'(0));
    chk("reset LO", 64'(LO), 64'(0));
    reset = 1'b0;
    m_hi = '0; m_lo = '0;

    for (int i = 0; i < 12; i++)
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, tbl[i].cyc, $sformatf("vec%0d", i));

    // Start of a mult during busy cycle 3 of a div must be ignored.
    @(negedge clk);
    start = 1'b1; op = MDU_DIV; A = 32'd100; B = 32'd7;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 200) begin
      cyc++;
      if (cyc == 3) begin start = 1'b1; op = MDU_MULT; A = 32'd3; B = 32'd5; end
      else start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    chk("ignore cycles", 64'(cyc), 64'(DC));
    chk("ignore HI", 64'(HI), 64'(2));
    chk("ignore LO", 64'(LO), 64'(14));
    repeat (8) @(negedge clk);
    chk("ignore late busy", 64'(busy), 64'(0));
    chk("ignore late HI", 64'(HI), 64'(2));
    chk("ignore late LO", 64'(LO), 64'(14));
    m_hi = 32'd2; m_lo = 32'd14;

    // Reset in busy cycle 4 of a div aborts it with no later commit.
    @(negedge clk);
    start = 1'b1; op = MDU_DIV; A = 32'd1000; B = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort busy c4", 64'(busy), 64'(1));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort busy", 64'(busy), 64'(0));
    chk("abort HI", 64'(HI), 64'(0));
    chk("abort LO", 64'(LO), 64'(0));
    repeat (12) @(negedge clk);
    chk("abort late busy", 64'(busy), 64'(0));
    chk("abort late HI", 64'(HI), 64'(0));
    chk("abort late LO", 64'(LO), 64'(0));
    m_hi = '0; m_lo = '0;

`ifdef MDU_MADD_EN
    run_op(MDU_MTLO, 32'hFFFFFFFF, 32'd0, 32'd0, 32'hFFFFFFFF, 0, "madd setup");
    run_op(MDU_MADDU, 32'd1, 32'd1, 32'd1, 32'd0, MC, "maddu carry");
    ops = '{MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO, MDU_MADD, MDU_MADDU};
`else
    run_op(MDU_MADD, 32'd5, 32'd6, m_hi, m_lo, 0, "madd disabled");
    run_op(MDU_MADDU, 32'd5, 32'd6, m_hi, m_lo, 0, "maddu disabled");
    ops = '{MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO};
`endif

    for (int i = 0; i < 60; i++) begin
      ro = ops[$urandom_range(0, ops.size() - 1)];
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 9) == 0) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
      ref_op(ro, ra, rb, m_hi, m_lo, ehi, elo, ecyc);
      run_op(ro, ra, rb, ehi, elo, ecyc, $sformatf("rand%0d op%0d", i, ro));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
